// File: rtl/mac_pkg.sv
// Shared definitions for the pipelined MAC: accumulation modes, Booth digit
// encoding and the signed saturation bounds used by the accumulate stage.
package mac_pkg;

  // Accumulation modes selected by the SAT parameter of mac_pipe.
  localparam int SAT_WRAP  = 0;
  localparam int SAT_CLAMP = 1;

  // Widest accumulator the bounds helper can describe.
  localparam int BOUND_W = 64;

  // One radix-4 Booth digit: magnitude 1 or 2 times the multiplicand, and sign.
  typedef struct packed {
    logic neg;
    logic two;
    logic one;
  } booth_sel_t;

  // Decode a Booth triplet {b[2i+1], b[2i], b[2i-1]} into a digit in -2..+2.
  function automatic booth_sel_t booth_decode(input logic [2:0] t);
    booth_sel_t s;
    s = '0;
    case (t)
      3'b001, 3'b010: s.one = 1'b1;
      3'b011:         s.two = 1'b1;
      3'b100:         begin s.two = 1'b1; s.neg = 1'b1; end
      3'b101, 3'b110: begin s.one = 1'b1; s.neg = 1'b1; end
      default:        s = '0;
    endcase
    return s;
  endfunction

  // Largest (upper=1) or smallest (upper=0) signed value representable in w bits.
  function automatic logic signed [BOUND_W-1:0] sat_bound(input int w, input logic upper);
    logic signed [BOUND_W-1:0] half;
    half = 64'sd1 <<< (w - 1);
    return upper ? (half - 64'sd1) : -half;
  endfunction

endpackage

// File: rtl/mac_pipe_mbe_mul.sv
// Combinational signed multiplier: radix-4 modified-Booth partial products
// reduced by a carry-save tree to two vectors and one final carry-propagate add.
module mbe_mul
  import mac_pkg::*;
#(
  parameter int A_W = 8,
  parameter int B_W = 8
) (
  input  logic signed [A_W-1:0]     a,
  input  logic signed [B_W-1:0]     b,
  output logic signed [A_W+B_W-1:0] p
);

  localparam int P_W  = A_W + B_W;
  // An odd-width multiplier is sign-extended by one bit so the digits pair up.
  localparam int BE_W = B_W + (B_W % 2);
  localparam int NPP  = BE_W / 2;
  // One row per Booth digit plus one row gathering the two's-complement +1s.
  localparam int NROW = NPP + 1;

  logic [BE_W:0]  b_ext;
  logic [P_W-1:0] a_ext;
  logic [P_W-1:0] rows [NROW];
  logic [P_W-1:0] sum_vec;
  logic [P_W-1:0] carry_vec;

  // The implicit zero below the multiplier LSB feeds the first Booth triplet.
  assign b_ext = {BE_W'(b), 1'b0};
  assign a_ext = P_W'(a);

  // Build the shifted partial-product rows and the negation correction row.
  always_comb begin
    booth_sel_t     sel;
    logic [P_W-1:0] mag;
    // NOTE: combinational logic uses blocking '=' and gives every output a value
    // before any branch, so no path leaves a variable unassigned (which would
    // infer a latch).
    sel       = '0;
    mag       = '0;
    rows[NPP] = '0;
    for (int i = 0; i < NPP; i++) begin
      sel = booth_decode(b_ext[2*i+2 -: 3]);
      if (sel.two)      mag = a_ext << 1;
      else if (sel.one) mag = a_ext;
      else              mag = '0;
      // Negative digits use ~mag here and add the missing +1 through rows[NPP].
      rows[i]          = (sel.neg ? ~mag : mag) << (2 * i);
      rows[NPP][2*i]   = sel.neg;
    end
  end

  // Wallace-style 3:2 reduction of all rows down to a sum and a carry vector.
  function automatic logic [2*P_W-1:0] csa_tree(input logic [P_W-1:0] r_in [NROW]);
    logic [P_W-1:0] r [NROW];
    logic [P_W-1:0] s;
    logic [P_W-1:0] c;
    int n;
    int m;
    r = r_in;
    n = NROW;
    for (int lvl = 0; lvl < NROW; lvl++) begin
      if (n > 2) begin
        m = 0;
        for (int k = 0; k < NROW; k += 3) begin
          if (k + 2 < n) begin
            s        = r[k] ^ r[k+1] ^ r[k+2];
            c        = ((r[k] & r[k+1]) | (r[k] & r[k+2]) | (r[k+1] & r[k+2])) << 1;
            r[m]     = s;
            r[m+1]   = c;
            m        = m + 2;
          end else if (k < n) begin
            // Rows left over at this level pass straight to the next one.
            r[m] = r[k];
            m    = m + 1;
            if (k + 1 < n) begin
              r[m] = r[k+1];
              m    = m + 1;
            end
          end
        end
        n = m;
      end
    end
    return {r[0], r[1]};
  endfunction

  assign {sum_vec, carry_vec} = csa_tree(rows);
  assign p                    = sum_vec + carry_vec;

endmodule

// File: rtl/mac_pipe.sv
// Two-stage signed multiply-accumulate with valid/ready handshake. S1 registers
// the Booth product, S2 accumulates with optional saturation and loads one
// result per segment terminated by 'last'.
module mac_pipe
  import mac_pkg::*;
#(
  parameter int A_W   = 8,
  parameter int B_W   = 8,
  parameter int ACC_W = 24,
  parameter int SAT   = SAT_CLAMP
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  input  logic                    clr,
  input  logic                    last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] acc_out,
  output logic                    ovf
);

  if (ACC_W < A_W + B_W) begin : g_width_check
    $error("mac_pipe: ACC_W must be at least A_W+B_W");
  end

  localparam logic signed [BOUND_W-1:0] MAX_WIDE = sat_bound(ACC_W, 1'b1);
  localparam logic signed [BOUND_W-1:0] MIN_WIDE = sat_bound(ACC_W, 1'b0);
  localparam logic signed [ACC_W-1:0]   ACC_MAX  = MAX_WIDE[ACC_W-1:0];
  localparam logic signed [ACC_W-1:0]   ACC_MIN  = MIN_WIDE[ACC_W-1:0];

  // Pipeline enable: everything holds while an unaccepted result is pending.
  logic en;

  logic signed [A_W+B_W-1:0] prod;

  // Stage 1 registers.
  logic                    s1_valid_d, s1_valid_q;
  logic                    s1_clr_d,   s1_clr_q;
  logic                    s1_last_d,  s1_last_q;
  logic signed [ACC_W-1:0] s1_prod_d,  s1_prod_q;

  // Stage 2 state and result registers.
  logic signed [ACC_W-1:0] acc_d,     acc_q;
  logic                    ovf_acc_d, ovf_acc_q;
  logic signed [ACC_W-1:0] acc_out_d, acc_out_q;
  logic                    ovf_d,     ovf_q;
  logic                    out_valid_d, out_valid_q;

  // Stage 2 datapath.
  logic                    s2_fire;
  logic                    load_result;
  logic signed [ACC_W:0]   base_x;
  logic signed [ACC_W:0]   sum_x;
  logic                    beat_ovf;
  logic signed [ACC_W-1:0] acc_new;
  logic                    ovf_acc_new;

  assign en       = !(out_valid_q && !out_ready);
  assign in_ready = en;

  mbe_mul #(
    .A_W (A_W),
    .B_W (B_W)
  ) u_mul (
    .a (a),
    .b (b),
    .p (prod)
  );

  // S1 next state: capture an accepted beat, record a bubble, or hold on stall.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_clr_d   = s1_clr_q;
    s1_last_d  = s1_last_q;
    s1_prod_d  = s1_prod_q;
    if (en) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_clr_d  = clr;
        s1_last_d = last;
        s1_prod_d = ACC_W'(prod);
      end
    end
  end

  // S2: one guard bit detects overflow; clamp or wrap, update the sticky flag
  // and load the result register on the segment's last beat.
  always_comb begin
    s2_fire     = en && s1_valid_q;
    load_result = s2_fire && s1_last_q;
    base_x      = s1_clr_q ? '0 : {acc_q[ACC_W-1], acc_q};
    sum_x       = base_x + {s1_prod_q[ACC_W-1], s1_prod_q};
    beat_ovf    = sum_x[ACC_W] ^ sum_x[ACC_W-1];
    if (beat_ovf && (SAT == SAT_CLAMP)) begin
      acc_new = sum_x[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      acc_new = sum_x[ACC_W-1:0];
    end
    ovf_acc_new = s1_clr_q ? beat_ovf : (ovf_acc_q | beat_ovf);

    acc_d       = s2_fire ? acc_new : acc_q;
    ovf_acc_d   = s2_fire ? ovf_acc_new : ovf_acc_q;
    acc_out_d   = load_result ? acc_new : acc_out_q;
    ovf_d       = load_result ? ovf_acc_new : ovf_q;
    // A new result wins over the consumer draining the previous one.
    out_valid_d = load_result || (out_valid_q && !out_ready);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking '<=' so every flop samples the
    // values from before the edge, independent of statement order.
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_clr_q    <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_prod_q   <= '0;
      acc_q       <= '0;
      ovf_acc_q   <= 1'b0;
      acc_out_q   <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_clr_q    <= s1_clr_d;
      s1_last_q   <= s1_last_d;
      s1_prod_q   <= s1_prod_d;
      acc_q       <= acc_d;
      ovf_acc_q   <= ovf_acc_d;
      acc_out_q   <= acc_out_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign acc_out   = acc_out_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_mac_pipe.sv
// Bench for mac_pipe: three instances (20-bit saturating, 16-bit saturating,
// 16-bit wrapping) share one input stream; results are compared with the
// constants from the test plan and with an arithmetic reference model.
module tb_mac_pipe;
  import mac_pkg::*;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, clr, last, out_ready;
  logic signed [7:0] a, b;

  logic in_ready0, in_ready1, in_ready2;
  logic out_valid0, out_valid1, out_valid2;
  logic ovf0, ovf1, ovf2;
  logic signed [19:0] acc_out0;
  logic signed [15:0] acc_out1, acc_out2;

  typedef struct packed {
    logic [NI-1:0][31:0] acc;
    logic [NI-1:0]       ovf;
  } res_t;

  res_t obs_q[$];
  res_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  longint m_acc [NI];
  bit     m_ovf [NI];
  int     cfg_w   [NI] = '{20, 16, 16};
  int     cfg_sat [NI] = '{1, 1, 0};

  always #5 clk = ~clk;

  mac_pipe #(.A_W(8), .B_W(8), .ACC_W(20), .SAT(SAT_CLAMP)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .clr(clr), .last(last), .out_valid(out_valid0),
    .out_ready(out_ready), .acc_out(acc_out0), .ovf(ovf0));

  mac_pipe #(.A_W(8), .B_W(8), .ACC_W(16), .SAT(SAT_CLAMP)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .clr(clr), .last(last), .out_valid(out_valid1),
    .out_ready(out_ready), .acc_out(acc_out1), .ovf(ovf1));

  mac_pipe #(.A_W(8), .B_W(8), .ACC_W(16), .SAT(SAT_WRAP)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .clr(clr), .last(last), .out_valid(out_valid2),
    .out_ready(out_ready), .acc_out(acc_out2), .ovf(ovf2));

  // Reference model: plain integer arithmetic on each accepted beat.
  function automatic void model_reset();
    for (int i = 0; i < NI; i++) begin
      m_acc[i] = 0;
      m_ovf[i] = 1'b0;
    end
  endfunction

  function automatic void model_beat(input int ma, input int mb, input bit mclr, input bit mlast);
    res_t   r;
    longint hi, lo, sum;
    bit     o;
    r = '0;
    for (int i = 0; i < NI; i++) begin
      hi  = (longint'(1) <<< (cfg_w[i] - 1)) - 1;
      lo  = -hi - 1;
      sum = (mclr ? longint'(0) : m_acc[i]) + longint'(ma) * longint'(mb);
      o   = (sum > hi) || (sum < lo);
      if (o) begin
        if (cfg_sat[i] != 0) begin
          sum = (sum > hi) ? hi : lo;
        end else begin
          sum = sum & ((longint'(1) <<< cfg_w[i]) - 1);
          if (sum > hi) sum = sum - (longint'(1) <<< cfg_w[i]);
        end
      end
      m_acc[i]  = sum;
      m_ovf[i]  = mclr ? o : (m_ovf[i] | o);
      r.acc[i]  = 32'(sum);
      r.ovf[i]  = m_ovf[i];
    end
    if (mlast) exp_q.push_back(r);
  endfunction

  // Collect every completed output handshake.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid0 === 1'b1 && out_ready === 1'b1) begin
      res_t r;
      checks++;
      if (out_valid1 !== 1'b1 || out_valid2 !== 1'b1) begin
        failures++;
        $display("FAIL out_valid_align got=%b%b%b want=111", out_valid0, out_valid1, out_valid2);
      end
      r        = '0;
      r.acc[0] = 32'(acc_out0);
      r.acc[1] = 32'(acc_out1);
      r.acc[2] = 32'(acc_out2);
      r.ovf    = {ovf2, ovf1, ovf0};
      obs_q.push_back(r);
    end
  end

  task automatic idle();
    in_valid = 1'b0;
    clr      = 1'b0;
    last     = 1'b0;
    a        = '0;
    b        = '0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one beat and hold it until the DUT accepts it.
  task automatic send_beat(input int ta, input int tb, input bit tclr, input bit tlast, input bit rand_bp);
    bit done;
    done     = 1'b0;
    a        = 8'(ta);
    b        = 8'(tb);
    clr      = tclr;
    last     = tlast;
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      if (in_ready0 === 1'b1) begin
        model_beat(ta, tb, tclr, tlast);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send_beat_timeout got=in_ready_low want=accept a=%0d b=%0d", ta, tb);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    out_ready = 1'b1;
    idle();
    model_reset();
    step(3);
    checks++;
    if ({out_valid0, out_valid1, out_valid2} !== 3'b000) begin
      failures++;
      $display("FAIL reset_out_valid got=%b%b%b want=000", out_valid0, out_valid1, out_valid2);
    end
    checks++;
    if (acc_out0 !== '0 || acc_out1 !== '0 || acc_out2 !== '0 || {ovf0, ovf1, ovf2} !== 3'b000) begin
      failures++;
      $display("FAIL reset_outputs got=%0d/%0d/%0d ovf=%b%b%b want=0", acc_out0, acc_out1, acc_out2, ovf0, ovf1, ovf2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    checks++;
    if ({in_ready0, in_ready1, in_ready2} !== 3'b111) begin
      failures++;
      $display("FAIL reset_in_ready got=%b%b%b want=111", in_ready0, in_ready1, in_ready2);
    end
  endtask

  task automatic test_single_product();
    res_t r;
    a = -8'sd128; b = -8'sd128; clr = 1'b1; last = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready0 !== 1'b1) begin
      failures++;
      $display("FAIL single_in_ready got=%b want=1", in_ready0);
    end
    model_beat(-128, -128, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    idle();
    @(negedge clk);
    checks++;
    if (out_valid0 !== 1'b0) begin
      failures++;
      $display("FAIL single_latency_early got=%b want=0", out_valid0);
    end
    @(negedge clk);
    checks++;
    if ({out_valid0, out_valid1, out_valid2} !== 3'b111 || int'(acc_out0) !== 16384) begin
      failures++;
      $display("FAIL single_latency got=%b acc=%0d want=1 acc=16384", out_valid0, acc_out0);
    end
    step(2);
    checks++;
    if (obs_q.size() !== 1) begin
      failures++;
      $display("FAIL single_count got=%0d want=1", obs_q.size());
    end
    while (obs_q.size() > 0) begin
      r = obs_q.pop_front();
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (int'(r.acc[i]) !== 16384 || r.ovf[i] !== 1'b0) begin
          failures++;
          $display("FAIL single_value[%0d] got=%0d ovf=%b want=16384 ovf=0", i, int'(r.acc[i]), r.ovf[i]);
        end
      end
    end
    exp_q.delete();
  endtask

  task automatic test_dot_product();
    res_t r;
    send_beat(3, 4, 1'b1, 1'b0, 1'b0);
    send_beat(-5, 6, 1'b0, 1'b0, 1'b0);
    send_beat(7, -8, 1'b0, 1'b0, 1'b0);
    send_beat(-1, -1, 1'b0, 1'b1, 1'b0);
    idle();
    step(5);
    checks++;
    if (obs_q.size() !== 1) begin
      failures++;
      $display("FAIL dot_pulses got=%0d want=1", obs_q.size());
    end
    while (obs_q.size() > 0) begin
      r = obs_q.pop_front();
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (int'(r.acc[i]) !== -73 || r.ovf[i] !== 1'b0) begin
          failures++;
          $display("FAIL dot_value[%0d] got=%0d ovf=%b want=-73 ovf=0", i, int'(r.acc[i]), r.ovf[i]);
        end
      end
    end
    exp_q.delete();
  endtask

  task automatic test_overflow();
    res_t r;
    int   e_acc [NI];
    bit   e_ovf [NI];
    e_acc = '{48387, 32767, -17149};
    e_ovf = '{1'b0, 1'b1, 1'b1};
    send_beat(127, 127, 1'b1, 1'b0, 1'b0);
    send_beat(127, 127, 1'b0, 1'b0, 1'b0);
    send_beat(127, 127, 1'b0, 1'b1, 1'b0);
    send_beat(2, 3, 1'b1, 1'b1, 1'b0);
    idle();
    step(5);
    checks++;
    if (obs_q.size() !== 2) begin
      failures++;
      $display("FAIL ovf_count got=%0d want=2", obs_q.size());
    end
    if (obs_q.size() == 2) begin
      r = obs_q.pop_front();
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (int'(r.acc[i]) !== e_acc[i] || r.ovf[i] !== e_ovf[i]) begin
          failures++;
          $display("FAIL ovf_value[%0d] got=%0d ovf=%b want=%0d ovf=%b", i, int'(r.acc[i]), r.ovf[i], e_acc[i], e_ovf[i]);
        end
      end
      r = obs_q.pop_front();
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (int'(r.acc[i]) !== 6 || r.ovf[i] !== 1'b0) begin
          failures++;
          $display("FAIL ovf_restart[%0d] got=%0d ovf=%b want=6 ovf=0", i, int'(r.acc[i]), r.ovf[i]);
        end
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    res_t r;
    out_ready = 1'b0;
    send_beat(9, 9, 1'b1, 1'b1, 1'b0);
    idle();
    for (int k = 0; k < 20 && out_valid0 !== 1'b1; k++) step(1);
    checks++;
    if (out_valid0 !== 1'b1) begin
      failures++;
      $display("FAIL bp_result_timeout got=%b want=1", out_valid0);
    end
    a = 8'sd1; b = 8'sd1; clr = 1'b1; last = 1'b1; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if ({in_ready0, in_ready1, in_ready2} !== 3'b000 || out_valid0 !== 1'b1) begin
        failures++;
        $display("FAIL bp_stall got=in_ready %b%b%b out_valid %b want=000 1", in_ready0, in_ready1, in_ready2, out_valid0);
      end
      checks++;
      if (int'(acc_out0) !== 81 || int'(acc_out1) !== 81 || int'(acc_out2) !== 81) begin
        failures++;
        $display("FAIL bp_hold got=%0d/%0d/%0d want=81", acc_out0, acc_out1, acc_out2);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_beat(1, 1, 1'b1, 1'b1, 1'b0);
    idle();
    step(5);
    checks++;
    if (obs_q.size() !== 2) begin
      failures++;
      $display("FAIL bp_count got=%0d want=2", obs_q.size());
    end
    if (obs_q.size() == 2) begin
      r = obs_q.pop_front();
      checks++;
      if (int'(r.acc[0]) !== 81 || int'(r.acc[2]) !== 81) begin
        failures++;
        $display("FAIL bp_first got=%0d want=81", int'(r.acc[0]));
      end
      r = obs_q.pop_front();
      checks++;
      if (int'(r.acc[0]) !== 1 || int'(r.acc[1]) !== 1 || r.ovf !== 3'b000) begin
        failures++;
        $display("FAIL bp_second got=%0d ovf=%b want=1 ovf=000", int'(r.acc[0]), r.ovf);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid_segment();
    res_t r;
    send_beat(2, 3, 1'b1, 1'b0, 1'b0);
    send_beat(4, 5, 1'b0, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid0, out_valid1, out_valid2, ovf0, ovf1, ovf2} !== 6'b0 ||
        acc_out0 !== '0 || acc_out1 !== '0 || acc_out2 !== '0) begin
      failures++;
      $display("FAIL midreset_async got=%0d/%0d/%0d ovf=%b%b%b want=0", acc_out0, acc_out1, acc_out2, ovf0, ovf1, ovf2);
    end
    model_reset();
    step(2);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    checks++;
    if (in_ready0 !== 1'b1) begin
      failures++;
      $display("FAIL midreset_in_ready got=%b want=1", in_ready0);
    end
    send_beat(5, 5, 1'b1, 1'b1, 1'b0);
    idle();
    step(5);
    checks++;
    if (obs_q.size() !== 1) begin
      failures++;
      $display("FAIL midreset_count got=%0d want=1", obs_q.size());
    end
    while (obs_q.size() > 0) begin
      r = obs_q.pop_front();
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (int'(r.acc[i]) !== 25 || r.ovf[i] !== 1'b0) begin
          failures++;
          $display("FAIL midreset_value[%0d] got=%0d ovf=%b want=25 ovf=0", i, int'(r.acc[i]), r.ovf[i]);
        end
      end
    end
    exp_q.delete();
  endtask

  function automatic int pick_operand();
    case ($urandom_range(0, 5))
      0:       return -128;
      1:       return 127;
      default: return int'($urandom_range(0, 255)) - 128;
    endcase
  endfunction

  task automatic test_random();
    res_t r, e;
    int   len;
    obs_q.delete();
    exp_q.delete();
    for (int seg = 0; seg < 40; seg++) begin
      len = int'($urandom_range(1, 5));
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 3) == 0) begin
          idle();
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        send_beat(pick_operand(), pick_operand(),
                  (j == 0) && ($urandom_range(0, 3) != 0), (j == len - 1), 1'b1);
      end
    end
    idle();
    out_ready = 1'b1;
    step(8);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL rand_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      r = obs_q.pop_front();
      e = exp_q.pop_front();
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (r.acc[i] !== e.acc[i] || r.ovf[i] !== e.ovf[i]) begin
          failures++;
          $display("FAIL rand_value[%0d] got=%0d ovf=%b want=%0d ovf=%b", i, int'(r.acc[i]), r.ovf[i], int'(e.acc[i]), e.ovf[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_product();
    test_dot_product();
    test_overflow();
    test_backpressure();
    test_reset_mid_segment();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
